// File: rtl/data_sync_tx_arbiter.sv
// Source-domain controller that round-robin arbitrates NUM_REQ requesters onto one
// unsync_bus/bus_enable pair, holding each word for HOLD_CYCLES and forcing a low gap after it.
module data_sync_tx_arbiter #(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned HOLD_CYCLES = 4,
    parameter int unsigned GAP_CYCLES  = 2
) (
    input  logic                          src_clk,
    input  logic                          src_rst_n,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            grant,
    output logic [DATA_WIDTH-1:0]         unsync_bus,
    output logic                          bus_enable,
    output logic                          busy
);

    localparam int unsigned PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned IDX_W   = PTR_W + 1;
    localparam int unsigned CNT_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        GAP  = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [PTR_W-1:0]       ptr_q, ptr_d;
    logic [NUM_REQ-1:0]     grant_q, grant_d;
    logic [DATA_WIDTH-1:0]  bus_q, bus_d;
    logic                   en_q, en_d;
    logic                   busy_q, busy_d;

    logic                   win_found;
    logic [PTR_W-1:0]       win_idx;
    logic [IDX_W-1:0]       scan_idx;
    logic [DATA_WIDTH-1:0]  win_data;
    logic [PTR_W-1:0]       ptr_next;

    // Round-robin pick: first set request scanning upward from the pointer, with wrap.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan_idx  = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            scan_idx = IDX_W'(ptr_q) + IDX_W'(k);
            if (scan_idx >= IDX_W'(NUM_REQ)) begin
                scan_idx = scan_idx - IDX_W'(NUM_REQ);
            end
            if (!win_found && req[scan_idx[PTR_W-1:0]]) begin
                win_found = 1'b1;
                win_idx   = scan_idx[PTR_W-1:0];
            end
        end
    end

    always_comb begin
        win_data = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (win_idx == PTR_W'(i)) begin
                win_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        ptr_next = (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + PTR_W'(1);
    end

    // Next-state and registered-output logic; bus data only moves on a grant.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        grant_d = '0;
        bus_d   = bus_q;
        en_d    = en_q;

        case (state_q)
            IDLE: begin
                if (win_found) begin
                    bus_d   = win_data;
                    grant_d = NUM_REQ'(1) << win_idx;
                    en_d    = 1'b1;
                    ptr_d   = ptr_next;
                    state_d = HOLD;
                    cnt_d   = CNT_W'(HOLD_CYCLES - 1);
                end
            end
            HOLD: begin
                en_d = 1'b1;
                if (cnt_q == '0) begin
                    en_d    = 1'b0;
                    state_d = GAP;
                    cnt_d   = CNT_W'(GAP_CYCLES - 1);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            GAP: begin
                en_d = 1'b0;
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                en_d    = 1'b0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge src_clk or negedge src_rst_n) begin
        if (!src_rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ptr_q   <= '0;
            grant_q <= '0;
            bus_q   <= '0;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            bus_q   <= bus_d;
            en_q    <= en_d;
            busy_q  <= busy_d;
        end
    end

    assign grant      = grant_q;
    assign unsync_bus = bus_q;
    assign bus_enable = en_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_data_sync_tx_arbiter.sv
// Scoreboard bench for data_sync_tx_arbiter: a cycle-count reference model predicts grants,
// bus data and enable/busy windows; a negedge monitor pops and compares.
module tb_data_sync_tx_arbiter;

    localparam int unsigned DW  = 8;
    localparam int unsigned NR  = 4;
    localparam int unsigned HC  = 4;
    localparam int unsigned GC  = 2;
    localparam int unsigned PER = HC + GC + 1;

    logic              src_clk;
    logic              src_rst_n;
    logic [NR-1:0]     req;
    logic [NR*DW-1:0]  req_data;
    logic [NR-1:0]     grant;
    logic [DW-1:0]     unsync_bus;
    logic              bus_enable;
    logic              busy;

    data_sync_tx_arbiter #(
        .DATA_WIDTH (DW),
        .NUM_REQ    (NR),
        .HOLD_CYCLES(HC),
        .GAP_CYCLES (GC)
    ) dut (
        .src_clk   (src_clk),
        .src_rst_n (src_rst_n),
        .req       (req),
        .req_data  (req_data),
        .grant     (grant),
        .unsync_bus(unsync_bus),
        .bus_enable(bus_enable),
        .busy      (busy)
    );

    initial src_clk = 1'b0;
    always #5 src_clk = ~src_clk;

    int checks = 0;
    int passes = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: actual=%0d required=%0d at %0t", name, act, exp, $time);
    endtask

    typedef struct {
        int unsigned   idx;
        logic [DW-1:0] data;
    } exp_t;

    exp_t sb[$];
    int   gseq[$];
    int   rises[$];

    // Reference model: a grant may happen at any edge at least PER edges after the last one.
    int unsigned   m_cyc   = 0;
    bit            m_have  = 1'b0;
    int unsigned   m_last  = 0;
    int unsigned   m_ptr   = 0;
    int unsigned   m_w     = 0;
    logic [NR-1:0] m_grant = '0;
    logic [DW-1:0] m_bus   = '0;

    initial forever begin
        @(posedge src_clk or negedge src_rst_n);
        if (!src_rst_n) begin
            m_cyc = 0; m_have = 1'b0; m_last = 0; m_ptr = 0; m_grant = '0; m_bus = '0;
        end else begin
            m_cyc++;
            m_grant = '0;
            if ((!m_have || m_cyc >= m_last + PER) && req != '0) begin
                for (int k = 0; k < NR; k++) begin
                    if (req[(m_ptr + k) % NR]) begin
                        m_w = (m_ptr + k) % NR;
                        break;
                    end
                end
                m_grant = NR'(1) << m_w;
                m_bus   = req_data[m_w*DW +: DW];
                m_ptr   = (m_w + 1) % NR;
                m_have  = 1'b1;
                m_last  = m_cyc;
                sb.push_back('{m_w, m_bus});
            end
        end
    end

    // Monitor: compares every negedge, pops the scoreboard on each grant, times enable runs.
    int          ncyc = 0;
    bit          en_prev = 1'b0;
    bit          have_fall = 1'b0;
    int          hi_run = 0;
    int          low_run = 0;
    int unsigned since;
    exp_t        e;
    int          gi;

    initial forever begin
        @(negedge src_clk);
        ncyc++;
        if (!src_rst_n) begin
            en_prev   = 1'b0;
            have_fall = 1'b0;
        end else begin
            since = m_cyc - m_last;
            chk("grant", 32'(grant), 32'(m_grant));
            chk("unsync_bus", 32'(unsync_bus), 32'(m_bus));
            chk("bus_enable", 32'(bus_enable), 32'(m_have && since < HC));
            chk("busy", 32'(busy), 32'(m_have && since < HC + GC));
            if (grant != '0) begin
                gi = -1;
                for (int k = 0; k < NR; k++) if (grant[k]) gi = k;
                gseq.push_back(gi);
                if (sb.size() == 0) begin
                    chk("sb_unexpected_grant", 32'(grant), 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("sb_grant", 32'(grant), 32'(NR'(1) << e.idx));
                    chk("sb_data", 32'(unsync_bus), 32'(e.data));
                end
            end
            if (bus_enable && !en_prev) begin
                rises.push_back(ncyc);
                if (have_fall) chk("gap_len_ok", 32'(low_run >= int'(GC + 1)), 32'd1);
                hi_run = 0;
            end
            if (!bus_enable && en_prev) begin
                chk("hold_len", 32'(hi_run), 32'(HC));
                have_fall = 1'b1;
                low_run   = 0;
            end
            if (bus_enable) hi_run++;
            else low_run++;
            en_prev = bus_enable;
        end
    end

    bit auto_drop = 1'b1;

    task automatic tick();
        @(negedge src_clk);
        if (auto_drop) req = req & ~grant;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic set_word(input int i, input logic [DW-1:0] v);
        req_data[i*DW +: DW] = v;
    endtask

    task automatic wait_grant(input string name);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (grant == '0 && n < 20);
        chk({name, "_seen"}, 32'(grant != '0), 32'd1);
    endtask

    function automatic int gat(input int k);
        return (gseq.size() > k) ? gseq[k] : -1;
    endfunction

    task automatic chk_outputs_zero(input string name);
        chk({name, "_grant"}, 32'(grant), 32'd0);
        chk({name, "_bus"}, 32'(unsync_bus), 32'd0);
        chk({name, "_en"}, 32'(bus_enable), 32'd0);
        chk({name, "_busy"}, 32'(busy), 32'd0);
    endtask

    int nseen;
    int g3;

    initial begin
        src_rst_n = 1'b0;
        req       = '0;
        req_data  = '0;
        #1;
        chk_outputs_zero("por");
        repeat (2) @(negedge src_clk);
        #2 src_rst_n = 1'b1;

        // Single word from requester 2.
        gseq.delete();
        tick();
        set_word(2, 8'd5);
        req[2] = 1'b1;
        ticks(12);
        chk("single_count", 32'(gseq.size()), 32'd1);
        chk("single_idx", 32'(gat(0)), 32'd2);
        chk("single_bus", 32'(unsync_bus), 32'd5);
        chk("single_idle_en", 32'(bus_enable), 32'd0);
        chk("single_idle_busy", 32'(busy), 32'd0);

        // Reset mid-HOLD, then all four requesters held continuously.
        set_word(1, 8'd15);
        req[1] = 1'b1;
        wait_grant("pre_reset");
        ticks(2);
        chk("pre_reset_en", 32'(bus_enable), 32'd1);
        #2 src_rst_n = 1'b0;
        #1;
        chk_outputs_zero("async_rst");
        auto_drop = 1'b0;
        set_word(0, 8'd5); set_word(1, 8'd15); set_word(2, 8'd20); set_word(3, 8'd25);
        req = 4'b1111;
        ticks(2);
        gseq.delete();
        rises.delete();
        #2 src_rst_n = 1'b1;
        nseen = 0;
        for (int n = 0; n < 60 && nseen < 5; n++) begin
            tick();
            if (grant != '0) nseen++;
        end
        req = '0;
        auto_drop = 1'b1;
        chk("rr_count", 32'(nseen), 32'd5);
        ticks(8);
        for (int k = 0; k < 5; k++) chk("rr_order", 32'(gat(k)), 32'(k % NR));
        for (int k = 1; k < 5; k++)
            chk("rr_period", 32'((rises.size() > k) ? rises[k] - rises[k-1] : -1), 32'(PER));

        // Fairness: after requester 1, requesters 0 and 2 rise together.
        gseq.delete();
        req[1] = 1'b1;
        wait_grant("fair_first");
        ticks(2);
        req = req | 4'b0101;
        for (int n = 0; n < 30 && gseq.size() < 3; n++) tick();
        ticks(8);
        chk("fair_0", 32'(gat(0)), 32'd1);
        chk("fair_1", 32'(gat(1)), 32'd2);
        chk("fair_2", 32'(gat(2)), 32'd0);

        // Glitch immunity: granted word changes during HOLD.
        set_word(2, 8'd5);
        req[2] = 1'b1;
        wait_grant("glitch");
        tick();
        set_word(2, 8'd20);
        ticks(2);
        chk("glitch_bus_hold", 32'(unsync_bus), 32'd5);
        ticks(8);
        chk("glitch_bus_idle", 32'(unsync_bus), 32'd5);

        // Dropped request: req[3] pulsed while busy.
        gseq.delete();
        set_word(0, 8'd7);
        req[0] = 1'b1;
        wait_grant("drop");
        tick();
        req[3] = 1'b1;
        tick();
        req[3] = 1'b0;
        ticks(12);
        g3 = 0;
        foreach (gseq[k]) if (gseq[k] == 3) g3++;
        chk("drop_no_grant3", 32'(g3), 32'd0);
        chk("drop_idle_en", 32'(bus_enable), 32'd0);
        chk("drop_idle_busy", 32'(busy), 32'd0);

        // Randomized requests, data churn and withdrawn requests.
        for (int n = 0; n < 300; n++) begin
            tick();
            if ($urandom_range(0, 3) == 0) req = req | NR'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) req = req & ~NR'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 0) set_word(int'($urandom_range(0, NR - 1)), DW'($urandom));
        end
        req = '0;
        ticks(12);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
